pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  ID stage holds a valid instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_ex_valid, id_ex_mem_read  in  1 each  EX holds a valid instruction; that instruction is a load.
REQ-007 id_ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 imem_busy  in  1  fetch has not returned an instruction this cycle.
REQ-010 dmem_req, dmem_resp_valid  in  1 each  MEM stage issues a data access; data memory completes it.
REQ-011 pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en  out  1 each  per-register write enables.
REQ-012 if_id_gen_bubble, id_ex_gen_bubble, ex_mem_gen_bubble, mem_wb_gen_bubble  out  1 each  per-register bubble requests, meaningful only with the matching wr_en.
REQ-013 state  out  2  current FSM state: RUN=0, DMEM_WAIT=1, FLUSH=2.
REQ-014 stall_cycles, bubble_count  out  CNT_W each  performance counters.

Function
REQ-015 Outputs are combinational from the state and the current inputs (Mealy); the state and counters are registered.
REQ-016 Default outputs: all wr_en=1 and all gen_bubble=0.
REQ-017 Priority order within one cycle: DMEM stall > redirect > load-use > imem_busy.
REQ-018 DMEM stall condition: dmem_req=1 and dmem_resp_valid=0, in RUN or FLUSH.
  - Outputs: pc, if_id, id_ex and ex_mem wr_en=0; mem_wb_wr_en=1 with mem_wb_gen_bubble=1.
  - Next state: DMEM_WAIT.
REQ-019 DMEM_WAIT with dmem_resp_valid=0: outputs as in REQ-018; state stays DMEM_WAIT; ex_redirect is ignored.
REQ-020 DMEM_WAIT with dmem_resp_valid=1: default outputs; next state RUN.
REQ-021 Redirect, in RUN with ex_redirect=1: pc_wr_en=1; if_id and id_ex wr_en=1 with gen_bubble=1; next state FLUSH.
REQ-022 FLUSH, one cycle: if_id_wr_en=1 with if_id_gen_bubble=1; other outputs default; next state RUN.
  - A second ex_redirect while in FLUSH is impossible and is ignored.
REQ-023 Load-use hazard condition: RUN, no higher-priority event, id_ex_valid and id_ex_mem_read and id_valid, id_ex_rd!=0, and id_ex_rd equals id_rs1 or id_rs2.
  - Outputs: pc_wr_en=0, if_id_wr_en=0, id_ex_wr_en=1 with id_ex_gen_bubble=1.
  - State stays RUN.
REQ-024 imem_busy with no higher-priority event: pc_wr_en=1, if_id_wr_en=1 with if_id_gen_bubble=1; downstream registers advance normally.
REQ-025 A comparison with register x0 never creates a hazard.
REQ-026 stall_cycles increments in every cycle where pc_wr_en=0.
REQ-027 bubble_count increments in every cycle where any (wr_en and gen_bubble) pair is 1, by 1 per cycle regardless of how many pairs.
REQ-028 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-029 state encoding 3 is unreachable; if entered, the next state is RUN and outputs are default.

Reset
REQ-030 While reset=1: state=RUN, stall_cycles=0, bubble_count=0.
REQ-031 While reset=1, outputs are forced to the defaults of REQ-016 regardless of inputs.
REQ-032 Reset asserted mid-DMEM_WAIT or mid-FLUSH returns to RUN on the next edge; no pending stall survives.

Verification
REQ-033 id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, all valid -> one cycle with pc_wr_en=0 and id_ex_gen_bubble=1; stall_cycles=1, bubble_count=1.
REQ-034 Same as REQ-033 but id_ex_rd=0 and id_rs1=0 -> default outputs; counters unchanged.
REQ-035 dmem_req=1 with dmem_resp_valid low for 3 cycles, then high -> state DMEM_WAIT for 3 cycles, RUN afterwards; stall_cycles=3, bubble_count=3.
REQ-036 ex_redirect=1 together with dmem_req=1 and dmem_resp_valid=0 -> DMEM_WAIT wins; FLUSH is not entered while the stall holds.
REQ-037 ex_redirect pulse in RUN -> cycle n: if_id and id_ex bubbles; cycle n+1: state=FLUSH with an if_id bubble; cycle n+2: RUN; bubble_count=2.
REQ-038 Preload stall_cycles to 2^CNT_W-2 (CNT_W=4 build), then stall 3 cycles -> counter holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard / stall controller for a classic 5-stage in-order pipeline. Each
// cycle it decides, for every pipeline register, whether that register loads
// (wr_en) and whether it loads a bubble instead of real data (gen_bubble).
// Outputs are combinational from the registered state and the current inputs.
//
// Event priority within one cycle (highest first):
//   data-memory stall > EX redirect > load-use hazard > fetch busy
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   id_valid, id_rs1/2    : instruction in ID and its source registers
//   id_ex_valid/mem_read  : EX holds a valid instruction / it is a load
//   id_ex_rd              : destination register of the instruction in EX
//   ex_redirect           : taken branch/jump resolved in EX this cycle
//   imem_busy             : fetch has no instruction this cycle
//   dmem_req/resp_valid   : MEM issues a data access / data memory completes
//   *_wr_en               : per pipeline-register write enables
//   *_gen_bubble          : per pipeline-register bubble requests
//   state                 : RUN=0, DMEM_WAIT=1, FLUSH=2
//   stall_cycles          : saturating count of cycles with pc_wr_en=0
//   bubble_count          : saturating count of cycles inserting any bubble
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_ex_valid,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_busy,
  input  logic             dmem_req,
  input  logic             dmem_resp_valid,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             id_ex_wr_en,
  output logic             ex_mem_wr_en,
  output logic             mem_wb_wr_en,
  output logic             if_id_gen_bubble,
  output logic             id_ex_gen_bubble,
  output logic             ex_mem_gen_bubble,
  output logic             mem_wb_gen_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_UNUSED    = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic dmem_stall;
  logic load_use;

  assign dmem_stall = dmem_req && !dmem_resp_valid;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid && id_ex_valid && id_ex_mem_read &&
                    (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

  always_comb begin
    state_next        = state_reg;
    pc_wr_en          = 1'b1;
    if_id_wr_en       = 1'b1;
    id_ex_wr_en       = 1'b1;
    ex_mem_wr_en      = 1'b1;
    mem_wb_wr_en      = 1'b1;
    if_id_gen_bubble  = 1'b0;
    id_ex_gen_bubble  = 1'b0;
    ex_mem_gen_bubble = 1'b0;
    mem_wb_gen_bubble = 1'b0;

    if (reset) begin
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (dmem_stall) begin
            // Freeze everything up to EX/MEM; drain WB with a bubble.
            pc_wr_en          = 1'b0;
            if_id_wr_en       = 1'b0;
            id_ex_wr_en       = 1'b0;
            ex_mem_wr_en      = 1'b0;
            mem_wb_gen_bubble = 1'b1;
            state_next        = ST_DMEM_WAIT;
          end else if (ex_redirect) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            if_id_gen_bubble = 1'b1;
            id_ex_gen_bubble = 1'b1;
            state_next       = ST_FLUSH;
          end else if (load_use) begin
            pc_wr_en         = 1'b0;
            if_id_wr_en      = 1'b0;
            id_ex_gen_bubble = 1'b1;
          end else if (imem_busy) begin
            if_id_gen_bubble = 1'b1;
          end
        end

        ST_DMEM_WAIT: begin
          // Redirects are ignored here: the branch in EX is frozen and will
          // be presented again once the memory access completes.
          if (!dmem_resp_valid) begin
            pc_wr_en          = 1'b0;
            if_id_wr_en       = 1'b0;
            id_ex_wr_en       = 1'b0;
            ex_mem_wr_en      = 1'b0;
            mem_wb_gen_bubble = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end

        ST_FLUSH: begin
          if (dmem_stall) begin
            pc_wr_en          = 1'b0;
            if_id_wr_en       = 1'b0;
            id_ex_wr_en       = 1'b0;
            ex_mem_wr_en      = 1'b0;
            mem_wb_gen_bubble = 1'b1;
            state_next        = ST_DMEM_WAIT;
          end else begin
            // The fetch issued alongside the redirect was still wrong-path.
            if_id_gen_bubble = 1'b1;
            state_next       = ST_RUN;
          end
        end

        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

  // Performance counters: index 0 = stall cycles, index 1 = bubble cycles.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = !pc_wr_en;
  assign cnt_inc[1] = (if_id_wr_en  && if_id_gen_bubble)  ||
                      (id_ex_wr_en  && id_ex_gen_bubble)  ||
                      (ex_mem_wr_en && ex_mem_gen_bubble) ||
                      (mem_wb_wr_en && mem_wb_gen_bubble);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cycles = cnt_reg[0];
  assign bubble_count = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Drives two controllers (32-bit and 4-bit counters) with identical stimulus
// and checks both against a reference model that classifies each cycle into
// one pipeline event and looks up the resulting enable/bubble pattern.
// Directed scenarios come first, then randomized traffic with random resets.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_ex_valid, id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic       ex_redirect, imem_busy, dmem_req, dmem_resp_valid;

  logic [8:0]  outs_w, outs_s;
  logic [1:0]  state_w, state_s;
  logic [31:0] stall_w, bub_w;
  logic [3:0]  stall_s, bub_s;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut_w (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_redirect(ex_redirect), .imem_busy(imem_busy), .dmem_req(dmem_req),
    .dmem_resp_valid(dmem_resp_valid),
    .pc_wr_en(outs_w[8]), .if_id_wr_en(outs_w[7]), .id_ex_wr_en(outs_w[6]),
    .ex_mem_wr_en(outs_w[5]), .mem_wb_wr_en(outs_w[4]),
    .if_id_gen_bubble(outs_w[3]), .id_ex_gen_bubble(outs_w[2]),
    .ex_mem_gen_bubble(outs_w[1]), .mem_wb_gen_bubble(outs_w[0]),
    .state(state_w), .stall_cycles(stall_w), .bubble_count(bub_w)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_redirect(ex_redirect), .imem_busy(imem_busy), .dmem_req(dmem_req),
    .dmem_resp_valid(dmem_resp_valid),
    .pc_wr_en(outs_s[8]), .if_id_wr_en(outs_s[7]), .id_ex_wr_en(outs_s[6]),
    .ex_mem_wr_en(outs_s[5]), .mem_wb_wr_en(outs_s[4]),
    .if_id_gen_bubble(outs_s[3]), .id_ex_gen_bubble(outs_s[2]),
    .ex_mem_gen_bubble(outs_s[1]), .mem_wb_gen_bubble(outs_s[0]),
    .state(state_s), .stall_cycles(stall_s), .bubble_count(bub_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running, 1 = waiting on data memory, 2 = flush.
  int     model_mode = 0;
  longint model_stall = 0;
  longint model_bub = 0;

  // Output pattern {pc, if_id, id_ex, ex_mem, mem_wb wr_en, 4 bubbles}
  // for each kind of event the pipeline can experience in a cycle.
  localparam logic [8:0] PAT_NORMAL   = 9'b11111_0000;
  localparam logic [8:0] PAT_DMEM     = 9'b00001_0001;
  localparam logic [8:0] PAT_REDIRECT = 9'b11111_1100;
  localparam logic [8:0] PAT_LOADUSE  = 9'b00111_0100;
  localparam logic [8:0] PAT_IFBUB    = 9'b11111_1000;

  function automatic logic [8:0] model_outs(output int nxt);
    logic lu;
    lu = id_valid && id_ex_valid && id_ex_mem_read && (id_ex_rd != 0) &&
         ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
    nxt = model_mode;
    if (reset) begin
      nxt = 0; return PAT_NORMAL;
    end
    if (model_mode == 1) begin
      if (!dmem_resp_valid) return PAT_DMEM;
      nxt = 0; return PAT_NORMAL;
    end
    if (dmem_req && !dmem_resp_valid) begin
      nxt = 1; return PAT_DMEM;
    end
    if (model_mode == 2) begin
      nxt = 0; return PAT_IFBUB;
    end
    if (ex_redirect) begin
      nxt = 2; return PAT_REDIRECT;
    end
    if (lu) return PAT_LOADUSE;
    if (imem_busy) return PAT_IFBUB;
    return PAT_NORMAL;
  endfunction

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // Inputs are set before calling; runs one clock cycle and checks both DUTs.
  task automatic step();
    logic [8:0] e;
    int nxt;
    e = model_outs(nxt);
    #1;
    check_val("outs_w", 64'(outs_w), 64'(e));
    check_val("outs_s", 64'(outs_s), 64'(e));
    @(posedge clk);
    if (reset) begin
      model_mode = 0; model_stall = 0; model_bub = 0;
    end else begin
      model_mode = nxt;
      if (!e[8]) model_stall++;
      if (|(e[7:4] & e[3:0])) model_bub++;
    end
    #1;
    check_val("state_w", 64'(state_w), 64'(model_mode));
    check_val("state_s", 64'(state_s), 64'(model_mode));
    check_val("stall_w", 64'(stall_w), 64'(model_stall));
    check_val("bub_w",   64'(bub_w),   64'(model_bub));
    check_val("stall_s", 64'(stall_s), 64'(sat4(model_stall)));
    check_val("bub_s",   64'(bub_s),   64'(sat4(model_bub)));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_ex_valid = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = '0;
    ex_redirect = 1'b0; imem_busy = 1'b0; dmem_req = 1'b0; dmem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    // Hostile inputs during reset must not leak to the outputs.
    dmem_req = 1'b1; ex_redirect = 1'b1; imem_busy = 1'b1;
    step();
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();
    check_val("rst_state", 64'(state_w), 64'(0));
    check_val("rst_stall", 64'(stall_w), 64'(0));

    // Load-use through rs2.
    id_valid = 1; id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5; id_rs1 = 1; id_rs2 = 5;
    #1;
    check_val("lu_pc_wr_en", 64'(outs_w[8]), 64'(0));
    check_val("lu_id_ex_bub", 64'(outs_w[2]), 64'(1));
    #1;
    step();
    check_val("lu_stall", 64'(stall_w), 64'(1));
    check_val("lu_bub", 64'(bub_w), 64'(1));

    // Load to x0 never hazards.
    do_reset();
    id_valid = 1; id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 0; id_rs1 = 0; id_rs2 = 5;
    step();
    check_val("x0_outs", 64'(outs_w), 64'(9'b11111_0000));
    check_val("x0_stall", 64'(stall_w), 64'(0));
    check_val("x0_bub", 64'(bub_w), 64'(0));

    // Three-cycle data memory wait.
    do_reset();
    dmem_req = 1; dmem_resp_valid = 0;
    for (int i = 0; i < 3; i++) step();
    check_val("dm_state_wait", 64'(state_w), 64'(1));
    dmem_resp_valid = 1;
    step();
    check_val("dm_state_run", 64'(state_w), 64'(0));
    check_val("dm_stall", 64'(stall_w), 64'(3));
    check_val("dm_bub", 64'(bub_w), 64'(3));

    // Redirect collides with a data memory stall: the stall wins.
    do_reset();
    ex_redirect = 1; dmem_req = 1; dmem_resp_valid = 0;
    step();
    check_val("col_state1", 64'(state_w), 64'(1));
    step();
    check_val("col_state2", 64'(state_w), 64'(1));
    ex_redirect = 0; dmem_resp_valid = 1;
    step();
    check_val("col_state3", 64'(state_w), 64'(0));

    // Redirect pulse: two bubble cycles, FLUSH for one cycle.
    do_reset();
    ex_redirect = 1;
    step();
    ex_redirect = 0;
    check_val("rd_state_flush", 64'(state_w), 64'(2));
    step();
    check_val("rd_state_run", 64'(state_w), 64'(0));
    check_val("rd_bub", 64'(bub_w), 64'(2));

    // Saturation of the 4-bit counter.
    do_reset();
    dmem_req = 1; dmem_resp_valid = 0;
    for (int i = 0; i < 14; i++) step();
    check_val("sat_pre", 64'(stall_s), 64'(14));
    for (int i = 0; i < 3; i++) step();
    check_val("sat_hold", 64'(stall_s), 64'(15));
    check_val("sat_wide", 64'(stall_w), 64'(17));

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_ex_valid     = ($urandom_range(0, 3) != 0);
      id_ex_mem_read  = ($urandom_range(0, 1) != 0);
      id_ex_rd        = 5'($urandom_range(0, 3));
      ex_redirect     = ($urandom_range(0, 9) == 0);
      imem_busy       = ($urandom_range(0, 4) == 0);
      dmem_req        = ($urandom_range(0, 5) == 0);
      dmem_resp_valid = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
